// File: rtl/seven_seg_scan_driver.sv
// Four-digit multiplexed seven-segment driver with dead-time blanking between
// digits, frame-coherent shadow registers and optional leading-zero blanking.
module seven_seg_scan_driver #(
  parameter int unsigned DEAD_CYCLES = 500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        refresh_clk,
  input  logic        en,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        lz_en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [1:0]  digit_idx
);

  localparam int unsigned CNT_W = (DEAD_CYCLES < 1) ? 1 : $clog2(DEAD_CYCLES + 1);
  localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              refresh_prev_q;
  logic [15:0]       sh_value_q, sh_value_d;
  logic [3:0]        sh_dp_q, sh_dp_d;
  logic              sh_lz_q, sh_lz_d;
  logic [3:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;

  logic              tick_c;
  logic [3:0]        nibble_c;
  logic              zero_above_c;

  // Active-low gfedcba font
  function automatic logic [6:0] hex_font(input logic [3:0] n);
    logic [6:0] f;
    case (n)
      4'h0: f = 7'h40;
      4'h1: f = 7'h79;
      4'h2: f = 7'h24;
      4'h3: f = 7'h30;
      4'h4: f = 7'h19;
      4'h5: f = 7'h12;
      4'h6: f = 7'h02;
      4'h7: f = 7'h78;
      4'h8: f = 7'h00;
      4'h9: f = 7'h10;
      4'hA: f = 7'h08;
      4'hB: f = 7'h03;
      4'hC: f = 7'h46;
      4'hD: f = 7'h21;
      4'hE: f = 7'h06;
      default: f = 7'h0E;
    endcase
    return f;
  endfunction

  assign tick_c = refresh_clk & ~refresh_prev_q;

  // Next-state: scan sequencing, dead-time counter and shadow reloads
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    sh_value_d = sh_value_q;
    sh_dp_d    = sh_dp_q;
    sh_lz_d    = sh_lz_q;

    if (!en) begin
      state_d = IDLE;
      idx_d   = 2'd0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (tick_c) begin
            state_d    = BLANK;
            idx_d      = 2'd0;
            cnt_d      = DEAD_LOAD;
            sh_value_d = value;
            sh_dp_d    = dp_in;
            sh_lz_d    = lz_en;
          end
        end
        BLANK, DRIVE: begin
          if (tick_c) begin
            // A tick always wins, even on the expiry cycle
            state_d = BLANK;
            idx_d   = idx_q + 2'd1;
            cnt_d   = DEAD_LOAD;
            if (idx_q == 2'd3) begin
              sh_value_d = value;
              sh_dp_d    = dp_in;
              sh_lz_d    = lz_en;
            end
          end else if (state_q == BLANK) begin
            if (cnt_q <= CNT_ONE) begin
              state_d = DRIVE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = 2'd0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output decode from next-state values so the pins are registered
  always_comb begin
    an_d         = 4'b1111;
    seg_d        = 7'h7F;
    dp_d         = 1'b1;
    nibble_c     = sh_value_d[{idx_d, 2'b00} +: 4];
    zero_above_c = 1'b0;

    case (idx_d)
      2'd3:    zero_above_c = (sh_value_d[15:12] == 4'h0);
      2'd2:    zero_above_c = (sh_value_d[15:8] == 8'h00);
      2'd1:    zero_above_c = (sh_value_d[15:4] == 12'h000);
      default: zero_above_c = 1'b0;
    endcase

    if (state_d == DRIVE) begin
      case (idx_d)
        2'd0:    an_d = 4'b1110;
        2'd1:    an_d = 4'b1101;
        2'd2:    an_d = 4'b1011;
        default: an_d = 4'b0111;
      endcase
      seg_d = (sh_lz_d && zero_above_c) ? 7'h7F : hex_font(nibble_c);
      dp_d  = ~sh_dp_d[idx_d];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      idx_q          <= 2'd0;
      cnt_q          <= '0;
      refresh_prev_q <= 1'b0;
      sh_value_q     <= 16'h0000;
      sh_dp_q        <= 4'h0;
      sh_lz_q        <= 1'b0;
      an_q           <= 4'b1111;
      seg_q          <= 7'h7F;
      dp_q           <= 1'b1;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      cnt_q          <= cnt_d;
      refresh_prev_q <= refresh_clk;
      sh_value_q     <= sh_value_d;
      sh_dp_q        <= sh_dp_d;
      sh_lz_q        <= sh_lz_d;
      an_q           <= an_d;
      seg_q          <= seg_d;
      dp_q           <= dp_d;
    end
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign dp        = dp_q;
  assign digit_idx = idx_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver with DEAD_CYCLES=4.
module tb_seven_seg_scan_driver;

  logic        clk;
  logic        reset;
  logic        refresh_clk;
  logic        en;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        lz_en;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [1:0]  digit_idx;

  int total;
  int bad;

  seven_seg_scan_driver #(.DEAD_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .refresh_clk(refresh_clk),
    .en         (en),
    .value      (value),
    .dp_in      (dp_in),
    .lz_en      (lz_en),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .digit_idx  (digit_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_blank(input string tag);
    chk({tag, "_an"},  16'(an),  16'hF);
    chk({tag, "_seg"}, 16'(seg), 16'h7F);
    chk({tag, "_dp"},  16'(dp),  16'h1);
  endtask

  task automatic chk_drive(input string tag, input logic [1:0] e_idx, input logic [3:0] e_an,
                           input logic [6:0] e_seg, input logic e_dp);
    chk({tag, "_idx"}, 16'(digit_idx), 16'(e_idx));
    chk({tag, "_an"},  16'(an),        16'(e_an));
    chk({tag, "_seg"}, 16'(seg),       16'(e_seg));
    chk({tag, "_dp"},  16'(dp),        16'(e_dp));
  endtask

  // One tick, four blank cycles, then the first drive cycle
  task automatic scan(input string tag, input logic [1:0] e_idx, input logic [3:0] e_an,
                      input logic [6:0] e_seg, input logic e_dp);
    @(negedge clk); refresh_clk = 1'b1;
    @(negedge clk); refresh_clk = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      chk({tag, "_blank_an"}, 16'(an), 16'hF);
    end
    chk({tag, "_blank_idx"}, 16'(digit_idx), 16'(e_idx));
    @(negedge clk);
    chk_drive(tag, e_idx, e_an, e_seg, e_dp);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1; refresh_clk = 1'b0; en = 1'b0;
    value = 16'h0000; dp_in = 4'h0; lz_en = 1'b0;
    repeat (2) @(negedge clk);
    chk_blank("reset");
    chk("reset_idx", 16'(digit_idx), 16'h0);

    reset = 1'b0; en = 1'b1; value = 16'h12AF;
    repeat (2) @(negedge clk);
    chk_blank("idle");

    // First frame and full digit rotation
    scan("d0_first", 2'd0, 4'b1110, 7'h0E, 1'b1);
    scan("d1", 2'd1, 4'b1101, 7'h08, 1'b1);
    scan("d2", 2'd2, 4'b1011, 7'h24, 1'b1);
    scan("d3", 2'd3, 4'b0111, 7'h79, 1'b1);
    scan("d0_wrap", 2'd0, 4'b1110, 7'h0E, 1'b1);

    // Value change mid-frame only shows after the wrap
    scan("mf_d1", 2'd1, 4'b1101, 7'h08, 1'b1);
    value = 16'h0000;
    scan("mf_d2", 2'd2, 4'b1011, 7'h24, 1'b1);
    scan("mf_d3", 2'd3, 4'b0111, 7'h79, 1'b1);
    scan("mf_d0", 2'd0, 4'b1110, 7'h40, 1'b1);
    scan("mf_d1n", 2'd1, 4'b1101, 7'h40, 1'b1);

    // Leading-zero suppression and decimal point
    lz_en = 1'b1; value = 16'h0070; dp_in = 4'b0010;
    scan("lz_old_d2", 2'd2, 4'b1011, 7'h40, 1'b1);
    scan("lz_old_d3", 2'd3, 4'b0111, 7'h40, 1'b1);
    scan("lz_d0", 2'd0, 4'b1110, 7'h40, 1'b1);
    scan("lz_d1", 2'd1, 4'b1101, 7'h78, 1'b0);
    scan("lz_d2", 2'd2, 4'b1011, 7'h7F, 1'b1);
    scan("lz_d3", 2'd3, 4'b0111, 7'h7F, 1'b1);
    scan("lz_d0b", 2'd0, 4'b1110, 7'h40, 1'b1);

    // Tick landing on the expiry edge keeps the display blank
    @(negedge clk); refresh_clk = 1'b1;
    @(negedge clk); refresh_clk = 1'b0;
    chk("exp_b1", 16'(an), 16'hF);
    repeat (2) begin
      @(negedge clk);
      chk("exp_b", 16'(an), 16'hF);
    end
    @(negedge clk);
    chk("exp_b4", 16'(an), 16'hF);
    refresh_clk = 1'b1;
    @(negedge clk);
    refresh_clk = 1'b0;
    chk("exp_nodrive_an", 16'(an), 16'hF);
    chk("exp_idx", 16'(digit_idx), 16'h2);
    repeat (3) begin
      @(negedge clk);
      chk("exp_reblank", 16'(an), 16'hF);
    end
    @(negedge clk);
    chk_drive("exp_drive", 2'd2, 4'b1011, 7'h7F, 1'b1);

    // Held-high refresh level advances exactly once
    @(negedge clk); refresh_clk = 1'b1;
    repeat (20) @(negedge clk);
    chk_drive("held", 2'd3, 4'b0111, 7'h7F, 1'b1);
    refresh_clk = 1'b0;
    @(negedge clk);
    chk_drive("held_rel", 2'd3, 4'b0111, 7'h7F, 1'b1);

    // Disable mid-drive, ticks ignored while disabled
    en = 1'b0; value = 16'hBEEF; lz_en = 1'b0; dp_in = 4'b0001;
    @(negedge clk);
    chk_blank("en0");
    chk("en0_idx", 16'(digit_idx), 16'h0);
    refresh_clk = 1'b1;
    @(negedge clk); refresh_clk = 1'b0;
    repeat (6) @(negedge clk);
    chk_blank("en0_tick");
    chk("en0_tick_idx", 16'(digit_idx), 16'h0);
    en = 1'b1;
    repeat (2) @(negedge clk);
    chk_blank("en1_idle");
    scan("en1_d0", 2'd0, 4'b1110, 7'h0E, 1'b0);
    scan("en1_d1", 2'd1, 4'b1101, 7'h06, 1'b1);

    // Reset mid-drive, then restart from digit 0
    reset = 1'b1;
    @(negedge clk);
    chk_blank("rst_mid");
    chk("rst_mid_idx", 16'(digit_idx), 16'h0);
    reset = 1'b0;
    @(negedge clk);
    scan("rst_d0", 2'd0, 4'b1110, 7'h0E, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
